// File: rtl/cgra_pkg.sv
// CGRA-wide constants and types.
//   OMN_FIFO_DEPTH / OMN_MAX_OUTSTANDING : defaults for the output memory node
//   omn_state_e                          : output memory node control states
package cgra_pkg;

  localparam int unsigned OMN_FIFO_DEPTH      = 4;
  localparam int unsigned OMN_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MREQ,
    S_WAIT,
    S_DONE
  } omn_state_e;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus types shared by all masters attached to the crossbar.
//   obi_req_t  : req, we, be, addr, wdata (master -> crossbar)
//   obi_resp_t : gnt, rvalid              (crossbar -> master)
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic gnt;
    logic rvalid;
  } obi_resp_t;

endpackage

// File: rtl/fifo_v3.sv
// First-word fall-through FIFO with synchronous active-low reset and flush.
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   flush_i          : empties the FIFO on the next edge (wins over push)
//   full_o, empty_o  : occupancy flags
//   data_i, push_i   : write side; a push while full is accepted only with a pop
//   data_o, pop_i    : head of queue (valid while !empty_o), pop request
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = AddrW + 1;

  logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + AddrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AddrW'(1);
      end
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through the occupancy count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/output_memory_node_strided.sv
// Drains a CGRA output stream into memory via one OBI master port, writing
// successive words output_stride_i bytes apart starting at output_addr_i.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   execute_i / done_o     : level start/hold; done after all responses return
//   output_addr_i          : base byte address
//   output_size_i          : transfer size in bytes (bits [1:0] ignored)
//   output_stride_i        : unsigned byte increment between writes
//   masters_req_o/resp_i   : OBI write master
//   din_i, din_v_i, din_r_o: stream input with ready/valid handshake
module output_memory_node_strided
  import cgra_pkg::*;
  import obi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = OMN_FIFO_DEPTH,
  parameter int unsigned MAX_OUTSTANDING = OMN_MAX_OUTSTANDING,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        execute_i,
  output logic        done_o,
  input  logic [31:0] output_addr_i,
  input  logic [15:0] output_size_i,
  input  logic [15:0] output_stride_i,
  output obi_req_t    masters_req_o,
  input  obi_resp_t   masters_resp_i,
  input  logic [31:0] din_i,
  input  logic        din_v_i,
  output logic        din_r_o
);

  omn_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] issued_cnt_q, issued_cnt_d;
  logic [31:0]          addr_offset_q, addr_offset_d;
  logic [3:0]           outstanding_q, outstanding_d;

  logic                 fifo_full, fifo_empty, fifo_flush, push;
  logic [31:0]          fifo_head;
  logic                 req, issue, rvalid;
  logic [CNT_WIDTH-1:0] size_words;

  assign size_words = CNT_WIDTH'(output_size_i >> 2);
  assign din_r_o    = ~fifo_full;
  assign push       = din_v_i & din_r_o;
  assign rvalid     = masters_resp_i.rvalid;
  assign req        = (state_q == S_MREQ) && !fifo_empty && (issued_cnt_q < word_cnt_q) &&
                      (outstanding_q < 4'(MAX_OUTSTANDING));
  assign issue      = req & masters_resp_i.gnt;
  assign done_o     = (state_q == S_DONE);

  fifo_v3 #(
    .DATA_WIDTH (32),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (fifo_flush),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (din_i),
    .push_i  (push),
    .data_o  (fifo_head),
    .pop_i   (issue)
  );

  // Saturates at zero so stray rvalids (e.g. left over from a reset) are harmless.
  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !rvalid) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!issue && rvalid && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    issued_cnt_d  = issued_cnt_q;
    addr_offset_d = addr_offset_q;
    fifo_flush    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        word_cnt_d    = size_words;
        issued_cnt_d  = '0;
        addr_offset_d = '0;
        if (execute_i) begin
          state_d = (size_words == '0) ? S_DONE : S_MREQ;
        end
      end
      S_MREQ: begin
        if (issue) begin
          issued_cnt_d  = issued_cnt_q + CNT_WIDTH'(1);
          addr_offset_d = addr_offset_q + {16'h0, output_stride_i};
        end
        if (issued_cnt_d == word_cnt_q) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Uses the next-state count so the final rvalid cycle already qualifies.
        if (outstanding_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!execute_i) begin
          state_d    = S_IDLE;
          fifo_flush = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    masters_req_o       = '0;
    masters_req_o.req   = req;
    masters_req_o.we    = 1'b1;
    masters_req_o.be    = 4'b1111;
    masters_req_o.addr  = output_addr_i + addr_offset_q;
    masters_req_o.wdata = fifo_head;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      word_cnt_q    <= '0;
      issued_cnt_q  <= '0;
      addr_offset_q <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      issued_cnt_q  <= issued_cnt_d;
      addr_offset_q <= addr_offset_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule
